// File: rtl/spi_4094_master_if.sv
// rtl/spi_4094_master_if.sv - handshake and serial bus bundle for the 4094 chain master
interface spi_4094_master_if #(
   parameter int NUM_BITS = 24
);
   logic                start;
   logic [NUM_BITS-1:0] din;
   logic                busy;
   logic                done;
   logic [NUM_BITS-1:0] dout;
   logic                sclk;
   logic                mosi;
   logic                strobe;
   logic                miso;

   modport master (
      input  start, din, miso,
      output busy, done, dout, sclk, mosi, strobe
   );

   modport slave (
      output start, din, miso,
      input  busy, done, dout, sclk, mosi, strobe
   );
endinterface

// File: rtl/spi_4094_master.sv
// rtl/spi_4094_master.sv - serialises a word into a daisy-chained 4094 chain, strobes it and reads back QS2
module spi_4094_master #(
   parameter int NUM_BITS      = 24,
   parameter int CLK_DIV       = 10,
   parameter int STROBE_CYCLES = 4
) (
   input logic                 clk,
   input logic                 reset_n,
   spi_4094_master_if.master   bus
);
   localparam int DIV_W = (CLK_DIV > 1)       ? $clog2(CLK_DIV)       : 1;
   localparam int BIT_W = (NUM_BITS > 1)      ? $clog2(NUM_BITS)      : 1;
   localparam int STB_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);
   localparam logic [STB_W-1:0] STB_LAST = STB_W'(STROBE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, STROBE} state_t;

   state_t              state;
   logic [DIV_W-1:0]    div_cnt;
   logic [BIT_W-1:0]    bit_idx;
   logic [STB_W-1:0]    stb_cnt;
   logic [NUM_BITS-1:0] tx_sr;
   logic [NUM_BITS-1:0] rx_sr;
   logic [NUM_BITS-1:0] tx_shl;
   logic [NUM_BITS-1:0] rx_shl;
   logic                sclk_r;
   logic                mosi_r;
   logic                strobe_r;
   logic                busy_r;
   logic                done_r;
   logic [NUM_BITS-1:0] dout_r;

   // Next-bit and readback shift values; written this way so NUM_BITS=1 stays legal
   always_comb begin
      tx_shl    = tx_sr << 1;
      rx_shl    = rx_sr << 1;
      rx_shl[0] = bus.miso;
   end

   // Transfer sequencer: idle -> (low, high) per bit -> strobe -> idle, all outputs registered
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         div_cnt  <= '0;
         bit_idx  <= '0;
         stb_cnt  <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         sclk_r   <= 1'b0;
         mosi_r   <= 1'b0;
         strobe_r <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         dout_r   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  tx_sr   <= bus.din;
                  mosi_r  <= bus.din[NUM_BITS-1];
                  busy_r  <= 1'b1;
                  bit_idx <= BIT_LAST;
                  div_cnt <= '0;
                  state   <= LOW;
               end
            end
            LOW: begin
               // QS2 moved on the previous falling sclk edge, so it is settled by the end of LOW
               if (div_cnt == DIV_LAST) begin
                  rx_sr   <= rx_shl;
                  div_cnt <= '0;
                  sclk_r  <= 1'b1;
                  state   <= HIGH;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            HIGH: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  sclk_r  <= 1'b0;
                  if (bit_idx != '0) begin
                     bit_idx <= bit_idx - 1'b1;
                     tx_sr   <= tx_shl;
                     mosi_r  <= tx_shl[NUM_BITS-1];
                     state   <= LOW;
                  end else begin
                     mosi_r   <= 1'b0;
                     strobe_r <= 1'b1;
                     stb_cnt  <= '0;
                     state    <= STROBE;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            STROBE: begin
               if (stb_cnt == STB_LAST) begin
                  strobe_r <= 1'b0;
                  busy_r   <= 1'b0;
                  done_r   <= 1'b1;
                  dout_r   <= rx_sr;
                  state    <= IDLE;
               end else begin
                  stb_cnt <= stb_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sclk   = sclk_r;
   assign bus.mosi   = mosi_r;
   assign bus.strobe = strobe_r;
   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.dout   = dout_r;
endmodule
